// File: rtl/wb_regfile_pkg.sv
// Shared widths and register-select type for the writeback register file,
// the MEM/WB stage and the hazard logic.
package wb_regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = 4'h0;

  typedef logic [ADDR_W-1:0] reg_sel_t;

endpackage

// File: rtl/wb_regfile_state_reg.sv
// Enabled state register with synchronous active-high clear; one instance
// holds one architectural register.
module state_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] state_new,
  output logic [WIDTH-1:0] state_curr
);

  logic [WIDTH-1:0] r_state;

  // Clear has priority over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (wen) begin
      r_state <= state_new;
    end else begin
      r_state <= r_state;
    end
  end

  assign state_curr = r_state;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the end of MEM/WB: R0 reads zero, two
// combinational read ports with same-cycle write-to-read bypass.
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] reg_write_select,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2
);

  import wb_regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] w_entry [NREGS];
  logic [NREGS-1:1]  w_wen;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Zero-force, then bypass, then storage; R0 is never bypassed.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_i,
    input logic [ADDR_W-1:0] src,
    input logic              we,
    input logic [ADDR_W-1:0] wsel,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    if (rst_i || (src == W_ZERO)) begin
      v = '0;
    end else if (we && (wsel == src)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  assign w_entry[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    assign w_wen[i] = regwrite && (reg_write_select == ADDR_W'(i));

    state_reg #(.WIDTH(DATA_W)) u_state_reg (
      .clk        (clk),
      .rst        (rst),
      .wen        (w_wen[i]),
      .state_new  (reg_write_data),
      .state_curr (w_entry[i])
    );
  end

  // Read port muxes.
  always_comb begin
    w_rd1 = read_mux(rst, src_reg1, regwrite, reg_write_select, reg_write_data, w_entry[src_reg1]);
    w_rd2 = read_mux(rst, src_reg2, regwrite, reg_write_select, reg_write_data, w_entry[src_reg2]);
  end

  assign src_data1 = w_rd1;
  assign src_data2 = w_rd2;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  import wb_regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic        regwrite;
  reg_sel_t    reg_write_select;
  logic [15:0] reg_write_data;
  reg_sel_t    src_reg1;
  reg_sel_t    src_reg2;
  logic [15:0] src_data1;
  logic [15:0] src_data2;

  int n_tests;
  int n_fail;

  wb_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .regwrite         (regwrite),
    .reg_write_select (reg_write_select),
    .reg_write_data   (reg_write_data),
    .src_reg1         (src_reg1),
    .src_reg2         (src_reg2),
    .src_data1        (src_data1),
    .src_data2        (src_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic we, input logic [3:0] sel,
                       input logic [15:0] d, input logic [3:0] s1, input logic [3:0] s2);
    rst = rs; regwrite = we; reg_write_select = sel; reg_write_data = d;
    src_reg1 = s1; src_reg2 = s2;
    #1;
  endtask

  initial begin
    logic [15:0] e1;
    logic [15:0] e2;
    logic [3:0]  j;
    n_tests = 0;
    n_fail  = 0;

    // Reset held two cycles with a write to R3 presented
    drive(1'b1, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd3);
    check("rst_c0_p1", src_data1, 16'h0000);
    check("rst_c0_p2", src_data2, 16'h0000);
    tick();
    check("rst_c1_p1", src_data1, 16'h0000);
    check("rst_c1_p2", src_data2, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 4'd3, 16'hBEEF, 4'd3, 4'd3);
    check("post_rst_r3", src_data1, 16'h0000);

    // Basic write then stored read
    drive(1'b0, 1'b1, 4'd5, 16'h1234, 4'd5, 4'd6);
    check("wr_r5_bypass", src_data1, 16'h1234);
    tick();
    drive(1'b0, 1'b0, 4'd5, 16'h1234, 4'd5, 4'd6);
    check("rd_r5", src_data1, 16'h1234);
    check("rd_r6", src_data2, 16'h0000);

    // Dual bypass on the same register
    drive(1'b0, 1'b1, 4'd7, 16'hA5A5, 4'd7, 4'd7);
    check("byp_r7_p1", src_data1, 16'hA5A5);
    check("byp_r7_p2", src_data2, 16'hA5A5);
    tick();
    drive(1'b0, 1'b0, 4'd7, 16'h0000, 4'd7, 4'd7);
    check("stored_r7_p1", src_data1, 16'hA5A5);
    check("stored_r7_p2", src_data2, 16'hA5A5);

    // R0 protection
    drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd5);
    check("r0_wr_same", src_data1, 16'h0000);
    check("r5_during_r0wr", src_data2, 16'h1234);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'hFFFF, 4'd0, 4'd0);
    check("r0_next_p1", src_data1, 16'h0000);
    check("r0_next_p2", src_data2, 16'h0000);

    // Reset mid-operation drops the write and the bypass
    drive(1'b0, 1'b1, 4'd9, 16'h00FF, 4'd9, 4'd5);
    tick();
    drive(1'b0, 1'b0, 4'd9, 16'h00FF, 4'd9, 4'd5);
    check("r9_stored", src_data1, 16'h00FF);
    drive(1'b1, 1'b1, 4'd9, 16'h7777, 4'd9, 4'd9);
    check("r9_in_rst_p1", src_data1, 16'h0000);
    check("r9_in_rst_p2", src_data2, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 4'd9, 16'h7777, 4'd9, 4'd5);
    check("r9_after_rst", src_data1, 16'h0000);
    check("r5_after_rst", src_data2, 16'h0000);

    // Sweep: fill R1..R15, then read complementary pairs
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'h1000 + 16'(i), 4'd0, 4'd0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      j = 4'(16 - i);
      drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'(i), j);
      e1 = (i == 0) ? 16'h0000 : 16'h1000 + 16'(i);
      e2 = (j == 4'd0) ? 16'h0000 : 16'h1000 + {12'h000, j};
      check($sformatf("sweep_p1_r%0d", i), src_data1, e1);
      check($sformatf("sweep_p2_r%0d", j), src_data2, e2);
    end

    // Bypass overrides a stale stored value; disabled write does not
    drive(1'b0, 1'b1, 4'd5, 16'hCAFE, 4'd5, 4'd6);
    check("byp_over_stored", src_data1, 16'hCAFE);
    check("no_byp_other", src_data2, 16'h1006);
    drive(1'b0, 1'b0, 4'd5, 16'hCAFE, 4'd5, 4'd6);
    check("we0_no_byp", src_data1, 16'h1005);
    tick();
    check("we0_no_commit", src_data1, 16'h1005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
